// File: rtl/fpu_mux_arbiter_3ch.sv
// rtl/fpu_mux_arbiter_3ch.sv - round-robin 3-channel arbiter in front of one shared FPU unit
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req[2:0]     level request per channel, held until its ack
//   unit_ready   shared-unit done flag (only looked at in WAIT)
//   unit_result  shared-unit result, valid with unit_ready
//   sel[1:0]     operand mux select (0..2)
//   unit_beg     one-cycle start pulse to the shared unit
//   ack[2:0]     one-hot one-cycle completion pulse
//   result_out   registered result, valid in the ack cycle, held otherwise
//   err          watchdog-expired flag, pulses with ack
//   busy         high whenever not IDLE
module fpu_mux_arbiter_3ch #(
  parameter int W   = 32,
  parameter int TMO = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic         unit_ready,
  input  logic [W-1:0] unit_result,
  output logic [1:0]   sel,
  output logic         unit_beg,
  output logic [2:0]   ack,
  output logic [W-1:0] result_out,
  output logic         err,
  output logic         busy
);

  localparam int CW = ($clog2(TMO) < 2) ? 2 : $clog2(TMO);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sel_q, sel_d;
  logic [1:0]     last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           unit_beg_q, unit_beg_d;
  logic [2:0]     ack_q, ack_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   result_q, result_d;

  // Search order starts one past the last granted channel and wraps.
  // Only meaningful when r != 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] c0, c1, c2;
    case (last)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (r[c0])      rr_pick = c0;
    else if (r[c1]) rr_pick = c1;
    else            rr_pick = c2;
  endfunction

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    unit_beg_d = 1'b0;
    ack_d      = 3'b000;
    err_d      = 1'b0;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          sel_d      = rr_pick(req, last_q);
          unit_beg_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A ready flag in the timeout cycle still counts as a good result.
        if (unit_ready) begin
          result_d = unit_result;
          ack_d    = 3'b001 << sel_q;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          ack_d   = 3'b001 << sel_q;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= 2'd0;
      last_q     <= 2'd2;
      cnt_q      <= '0;
      unit_beg_q <= 1'b0;
      ack_q      <= 3'b000;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      unit_beg_q <= unit_beg_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
    end
  end

  assign sel        = sel_q;
  assign unit_beg   = unit_beg_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign result_out = result_q;

endmodule

// File: tb/tb_fpu_mux_arbiter_3ch.sv
// tb/tb_fpu_mux_arbiter_3ch.sv - scoreboard bench for fpu_mux_arbiter_3ch
module tb_fpu_mux_arbiter_3ch;

  localparam int W   = 32;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic         rdy_resp;
  logic         rdy_noise;
  logic         unit_ready;
  logic [W-1:0] unit_result;
  logic [1:0]   sel;
  logic         unit_beg;
  logic [2:0]   ack;
  logic [W-1:0] result_out;
  logic         err;
  logic         busy;

  assign unit_ready = rdy_resp | rdy_noise;

  fpu_mux_arbiter_3ch #(.W(W), .TMO(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .unit_ready  (unit_ready),
    .unit_result (unit_result),
    .sel         (sel),
    .unit_beg    (unit_beg),
    .ack         (ack),
    .result_out  (result_out),
    .err         (err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ack;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [2:0]  req_at_edge = 3'b000;
  int          m_last   = 2;
  logic [31:0] m_result = 32'h0;
  int          resp_delay = 0;
  logic        beg_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 0; k < 3; k++) begin
      if (r[(last + 1 + k) % 3]) return (last + 1 + k) % 3;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    req_at_edge <= req;
  end

  // Shared-unit model: on each start pulse, predicts the grant and the
  // response, pushes it to the scoreboard, then raises ready after
  // resp_delay WAIT cycles (negative delay = never).
  initial begin
    exp_t        e;
    logic [31:0] val;
    int          g;
    rdy_resp    = 1'b0;
    unit_result = 32'h0;
    forever begin
      @(negedge clk);
      if (unit_beg && !rst) begin
        val = $urandom;
        g   = pick(req_at_edge, m_last);
        check("issue_sel", {30'd0, sel}, g);
        e.ack    = 3'b001 << g;
        e.err    = (resp_delay < 0) || (resp_delay >= TMO);
        e.res    = e.err ? m_result : val;
        m_result = e.res;
        m_last   = g;
        sb.push_back(e);
        if (resp_delay >= 0) begin
          repeat (resp_delay + 1) @(negedge clk);
          rdy_resp    = 1'b1;
          unit_result = val;
          @(negedge clk);
          rdy_resp    = 1'b0;
          unit_result = ~val;
        end
      end
    end
  end

  // Output monitor: every ack is popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sel == 2'b11) check("sel_range", {30'd0, sel}, 0);
      if (unit_beg) check("beg_one_cycle", {31'd0, beg_prev}, 0);
      if (ack != 3'b000) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {29'd0, ack}, 0);
        end else begin
          e = sb.pop_front();
          check("ack", {29'd0, ack}, {29'd0, e.ack});
          check("result", result_out, e.res);
          check("err", {31'd0, err}, {31'd0, e.err});
          check("busy_in_resp", {31'd0, busy}, 1);
        end
      end else if (err) begin
        check("err_without_ack", {31'd0, err}, 0);
      end
    end
    beg_prev <= unit_beg;
  end

  task automatic wait_beg(output int c);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (unit_beg) seen = 1'b1;
    end
    check("beg_seen", {31'd0, seen}, 1);
    c = cyc;
  endtask

  task automatic wait_ack(output int c);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ack != 3'b000) seen = 1'b1;
    end
    check("ack_seen", {31'd0, seen}, 1);
    c = cyc;
  endtask

  task automatic run_one(input logic [2:0] r, input int d, output int tb_, output int ta_);
    resp_delay = d;
    @(negedge clk);
    req = r;
    wait_beg(tb_);
    wait_ack(ta_);
    req = 3'b000;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sel"}, {30'd0, sel}, 0);
    check({tag, "_beg"}, {31'd0, unit_beg}, 0);
    check({tag, "_ack"}, {29'd0, ack}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_result"}, result_out, 0);
  endtask

  logic [2:0] rr_exp[4];

  initial begin
    int tb_, ta_, tp_;
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    rst = 1'b1; req = 3'b000; rdy_noise = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Single request on ch_1 with the unit answering in the first WAIT cycle.
    resp_delay = 0;
    @(negedge clk);
    req = 3'b010;
    wait_beg(tb_);
    check("single_sel", {30'd0, sel}, 1);
    check("single_busy", {31'd0, busy}, 1);
    @(negedge clk);
    check("single_beg_low", {31'd0, unit_beg}, 0);
    wait_ack(ta_);
    req = 3'b000;
    check("single_lat", ta_ - tb_, 2);
    check("single_ack", {29'd0, ack}, 3'b010);
    check("single_result", result_out, m_result);
    @(negedge clk);
    check("single_idle_busy", {31'd0, busy}, 0);
    check("single_ack_drop", {29'd0, ack}, 0);

    // Priority after grants: last=1 -> 011 gives ch_0, then 110 gives ch_1.
    run_one(3'b011, 0, tb_, ta_);
    check("prio_a_ack", {29'd0, ack}, 3'b001);
    run_one(3'b110, 0, tb_, ta_);
    check("prio_b_ack", {29'd0, ack}, 3'b010);
    run_one(3'b100, 0, tb_, ta_);
    check("prio_c_ack", {29'd0, ack}, 3'b100);

    // Round robin with all requests held.
    resp_delay = 0;
    @(negedge clk);
    req = 3'b111;
    tp_ = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(ta_);
      check("rr_ack", {29'd0, ack}, {29'd0, rr_exp[i]});
      if (i > 0) check("rr_spacing", ta_ - tp_, 4);
      tp_ = ta_;
    end
    req = 3'b000;

    // Watchdog: unit never answers.
    run_one(3'b001, -1, tb_, ta_);
    check("wd_lat", ta_ - tb_, TMO + 1);
    check("wd_err", {31'd0, err}, 1);
    @(negedge clk);
    check("wd_busy_drop", {31'd0, busy}, 0);

    // Ready coincides with the last watchdog cycle: result wins.
    run_one(3'b010, TMO - 1, tb_, ta_);
    check("coinc_lat", ta_ - tb_, TMO + 1);
    check("coinc_err", {31'd0, err}, 0);

    // Ready noise in IDLE is ignored.
    @(negedge clk);
    rdy_noise = 1'b1;
    @(negedge clk);
    rdy_noise = 1'b0;
    repeat (3) @(negedge clk);
    check("noise_idle_busy", {31'd0, busy}, 0);

    // Ready noise during ISSUE is ignored; the real answer comes later.
    resp_delay = 1;
    @(negedge clk);
    req = 3'b100;
    wait_beg(tb_);
    rdy_noise = 1'b1;
    @(negedge clk);
    rdy_noise = 1'b0;
    wait_ack(ta_);
    req = 3'b000;
    check("noise_issue_lat", ta_ - tb_, 3);

    // Reset in the middle of WAIT drops the transaction.
    resp_delay = -1;
    @(negedge clk);
    req = 3'b001;
    wait_beg(tb_);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_last   = 2;
    m_result = 32'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("postrst");
    run_one(3'b001, 0, tb_, ta_);
    check("postrst_ack", {29'd0, ack}, 3'b001);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
